// File: rtl/encod_coluna_letra.sv
// encod_coluna_letra: segment pattern to column code encoder with result FIFO.
// Define ENCOD_ERR_CNT_EN to add the saturating err_cnt output.
module encod_coluna_letra #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       seg_a,
  input  logic       seg_b,
  input  logic       seg_c,
  input  logic       seg_d,
  input  logic       seg_e,
  input  logic       seg_f,
  input  logic       seg_g,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       amb,
  output logic       err,
  output logic       out_valid,
  input  logic       out_ready
`ifdef ENCOD_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if (FIFO_DEPTH < 1 || FIFO_DEPTH > 4) begin : g_bad_depth
    $error("FIFO_DEPTH must be within 1..4");
  end

  typedef struct packed {
    logic [2:0] code;
    logic       amb;
    logic       err;
  } res_t;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } state_t;

  logic [6:0]    pat;
  res_t          enc;
  res_t          head;
  res_t          mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  state_t        state;
  state_t        state_n;
  logic          full;
  logic          push;
  logic          pop;

  assign pat = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};

  always_comb begin
    enc = '0;
    unique case (1'b1)
      pat == 7'b0001000: enc.code = 3'd0;
      pat == 7'b1100000: enc.code = 3'd1;
      pat == 7'b0110001: enc.code = 3'd2;
      pat == 7'b1000010: enc.code = 3'd3;
      pat == 7'b0110000: enc.code = 3'd4;
      pat == 7'b1111111: begin
        enc.code = 3'd5;
        enc.amb  = 1'b1;
      end
      default: enc.err = 1'b1;
    endcase
  end

  assign full      = (state == FULL);
  assign out_valid = (state != EMPTY);
  // A same-cycle pop frees the slot, so a full FIFO still accepts.
  assign in_ready  = !reset && (!full || out_ready);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    state_n = state;
    unique case (state)
      EMPTY: begin
        if (push && !pop)
          state_n = (FIFO_DEPTH == 1) ? FULL : PARTIAL;
      end
      PARTIAL: begin
        if (push && !pop && count == CNT_LAST)
          state_n = FULL;
        else if (pop && !push && count == CNT_ONE)
          state_n = EMPTY;
      end
      FULL: begin
        if (pop && !push)
          state_n = (FIFO_DEPTH == 1) ? EMPTY : PARTIAL;
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_n;
      if (push)
        wr_ptr <= ptr_inc(wr_ptr);
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= enc;
  end

  assign head = out_valid ? mem[rd_ptr] : '0;
  assign A    = head.code[2];
  assign B    = head.code[1];
  assign C    = head.code[0];
  assign amb  = head.amb;
  assign err  = head.err;

`ifdef ENCOD_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      err_cnt <= '0;
    else if (push && enc.err && err_cnt != 8'hFF)
      err_cnt <= err_cnt + 1'b1;
  end
`endif

endmodule

// File: doc/encod_coluna_letra.md
ENCOD_COLUNA_LETRA -- requirements
Module: encod_coluna_letra

Interface
REQ-001 Parameter FIFO_DEPTH, default 2 (1..4): number of result-FIFO entries.
REQ-002 clk  input  1  rising-edge clock; the block's only clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 seg_a..seg_g  input  1 each  segment pattern to encode; a = MSB of pattern word abcdefg.
REQ-005 in_valid  input  1  pattern on seg_a..seg_g is valid this cycle.
REQ-006 in_ready  output  1  block accepts the pattern this cycle.
REQ-007 A, B, C  output  1 each  recovered 3-bit column code; A = MSB.
REQ-008 amb  output  1  pattern was 1111111; code shown is the lowest match.
REQ-009 err  output  1  pattern matches no column code; A,B,C = 000.
REQ-010 out_valid  output  1  A,B,C,amb,err hold a FIFO head entry.
REQ-011 out_ready  input  1  consumer takes the head entry this cycle.
REQ-012 err_cnt  output  8  saturating count of err results (present only with ENCOD_ERR_CNT_EN).

Function
REQ-013 Encode table, abcdefg -> ABC: 0001000->000, 1100000->001, 0110001->010, 1000010->011, 0110000->100, 1111111->101 with amb=1; any other pattern -> err=1, ABC=000.
REQ-014 Transfer in: in_valid & in_ready; transfer out: out_valid & out_ready.
REQ-015 in_ready = 1 when FIFO not full, or when full and out_ready=1 (same-cycle pop frees the slot).
REQ-016 Latency: an accepted pattern appears at the outputs no earlier than the next cycle, and the following cycle when the FIFO was empty (1-cycle latency).
REQ-017 Results leave in acceptance order; none dropped or duplicated.
REQ-018 A,B,C,amb,err stay stable while out_valid=1 and out_ready=0.
REQ-019 Occupancy counter 0..FIFO_DEPTH; simultaneous push and pop leaves it unchanged; read/write pointers wrap modulo FIFO_DEPTH.
REQ-020 out_valid=0 when the FIFO is empty; out_ready then has no effect.
REQ-021 in_valid while full and out_ready=0: not accepted, in_ready=0, pattern must be held by the source.
REQ-022 Control FSM states EMPTY, PARTIAL, FULL from occupancy: EMPTY->PARTIAL on push without pop; PARTIAL->FULL on push without pop reaching FIFO_DEPTH; FULL->PARTIAL or PARTIAL->EMPTY on pop without push; otherwise hold. With FIFO_DEPTH=1 PARTIAL is unused.

Reset
REQ-023 With reset=1 at a clk edge: FIFO emptied, FSM=EMPTY, out_valid=0, A=B=C=0, amb=0, err=0, err_cnt=0.
REQ-024 in_ready=0 during any cycle with reset=1; a transfer during reset is discarded.
REQ-025 Reset mid-stream discards all queued results; first accept after reset deasserts behaves as from power-up.

Configuration
REQ-026 Macro ENCOD_ERR_CNT_EN defined: err_cnt exists, increments by 1 on each accepted pattern with err=1, saturates at 255, cleared only by reset.
REQ-027 Macro ENCOD_ERR_CNT_EN undefined: err_cnt port and its logic absent; all other behaviour identical.

Verification
REQ-028 Post-reset: reset high 3 cycles -> out_valid=0, ABC=000, amb=0, err=0, in_ready=0 during reset, 1 after.
REQ-029 All table entries sent back-to-back, out_ready=1 -> outputs 000,001,010,011,100,101(amb=1) in order, one per cycle, 1-cycle latency.
REQ-030 Pattern 0000001, then 1111110 -> two results err=1, ABC=000; err_cnt=2 with ENCOD_ERR_CNT_EN.
REQ-031 FIFO_DEPTH=2, out_ready=0, send 0110001, 1000010, 1100000 -> in_ready=0 after second accept, third held; raise out_ready -> 010, 011, 001 in order, nothing lost.
REQ-032 Full FIFO, in_valid=1 and out_ready=1 same cycle -> push and pop both occur, occupancy stays 2, FSM stays FULL.
REQ-033 Reset asserted with 2 entries queued -> out_valid=0 next cycle; 1100000 sent after reset -> single output 001.
